// File: rtl/morse_digit_display_if.sv
// rtl/morse_digit_display_if.sv - glyph/status inputs and scanned display outputs
// The decoder side drives Seg/Status/Clr; the display side drives SegY/AnY/CntY/ErrY.
interface morse_digit_display_if;
  logic [6:0] Seg;
  logic [1:0] Status;
  logic       Clr;
  logic [6:0] SegY;
  logic [3:0] AnY;
  logic [2:0] CntY;
  logic       ErrY;

  modport master (
    output Seg, Status, Clr,
    input  SegY, AnY, CntY, ErrY
  );

  modport slave (
    input  Seg, Status, Clr,
    output SegY, AnY, CntY, ErrY
  );
endinterface

// File: rtl/morse_digit_display.sv
// rtl/morse_digit_display.sv - 4-digit history of decoded Morse glyphs, multiplexed onto a 7-segment display
// Optional newest-digit error blink is built when MORSE_DISP_BLINK_EN is defined.
module morse_digit_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic                   C,
  input  logic                   R,
  morse_digit_display_if.slave   bus
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [3:0][6:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic [1:0]      idx_q, idx_d;
  logic            prev_q, prev_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            err_q, err_d;
  logic            push;

`ifdef MORSE_DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`endif

  // One push per symbol: only the 0->1 transition of Status[1] counts.
  assign push = bus.Status[1] & ~prev_q;

  always_comb begin
    dig_d  = dig_q;
    cnt_d  = cnt_q;
    ref_d  = ref_q;
    idx_d  = idx_q;
    prev_d = bus.Status[1];
    err_d  = (bus.Status == 2'b11);
    an_d   = 4'b0001 << idx_q;
    seg_d  = dig_q[idx_q];

    if (bus.Clr) begin
      dig_d = '0;
      cnt_d = 3'd0;
    end else if (push) begin
      dig_d = {dig_q[2:0], bus.Seg};
      cnt_d = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
    end

    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      ref_d = ref_q + RW'(1);
    end

`ifdef MORSE_DISP_BLINK_EN
    if (err_q && !phase_q && (idx_q == 2'd0)) begin
      seg_d = 7'b0000000;
    end
`endif
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      dig_q  <= '0;
      cnt_q  <= 3'd0;
      ref_q  <= '0;
      idx_q  <= 2'd0;
      prev_q <= 1'b0;
      an_q   <= 4'b0001;
      seg_q  <= 7'b0000000;
      err_q  <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      cnt_q  <= cnt_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
      prev_q <= prev_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      err_q  <= err_d;
    end
  end

  assign bus.SegY = seg_q;
  assign bus.AnY  = an_q;
  assign bus.CntY = cnt_q;
  assign bus.ErrY = err_q;

endmodule

// File: tb/tb_morse_digit_display.sv
// tb/tb_morse_digit_display.sv - scoreboard bench for morse_digit_display
// Expected outputs are queued per clock from a behavioural model and popped after each edge.
module tb_morse_digit_display;
  localparam int RDIV = 4;
  localparam int BDIV = 8;

  logic C;
  logic R;
  morse_digit_display_if bus_if ();

  morse_digit_display #(.REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) dut (
    .C   (C),
    .R   (R),
    .bus (bus_if.slave)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [6:0] m_buf [4];
  logic [2:0] m_cnt;
  int         m_ref;
  int         m_idx;
  logic       m_prev;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_err;
  int         m_bcnt;
  logic       m_phase;
  logic [14:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("miscompare %s", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_buf[i] = 7'b0;
    m_cnt = 3'd0; m_ref = 0; m_idx = 0; m_prev = 1'b0;
    m_an = 4'b0001; m_seg = 7'b0; m_err = 1'b0;
    m_bcnt = 0; m_phase = 1'b1;
    exp_q.delete();
  endtask

  // Advance the model one clock from the current inputs, clock the DUT, compare.
  task automatic tick();
    logic [6:0] n_buf [4];
    logic [2:0] n_cnt;
    int n_ref, n_idx, n_bcnt;
    logic n_phase, push;
    logic [3:0] n_an;
    logic [6:0] n_seg;
    logic [14:0] e;
    for (int i = 0; i < 4; i++) n_buf[i] = m_buf[i];
    n_cnt = m_cnt;
    push = bus_if.Status[1] && !m_prev;
    if (bus_if.Clr) begin
      for (int i = 0; i < 4; i++) n_buf[i] = 7'b0;
      n_cnt = 3'd0;
    end else if (push) begin
      n_buf[3] = m_buf[2]; n_buf[2] = m_buf[1]; n_buf[1] = m_buf[0]; n_buf[0] = bus_if.Seg;
      n_cnt = (m_cnt >= 3'd4) ? 3'd4 : m_cnt + 3'd1;
    end
    n_ref = (m_ref == RDIV - 1) ? 0 : m_ref + 1;
    n_idx = (m_ref == RDIV - 1) ? (m_idx + 1) % 4 : m_idx;
    n_bcnt = (m_bcnt == BDIV - 1) ? 0 : m_bcnt + 1;
    n_phase = (m_bcnt == BDIV - 1) ? !m_phase : m_phase;
    n_an = 4'b0001 << m_idx;
    n_seg = m_buf[m_idx];
`ifdef MORSE_DISP_BLINK_EN
    if (m_err && !m_phase && m_idx == 0) n_seg = 7'b0;
`endif
    exp_q.push_back({n_an, n_seg, n_cnt, bus_if.Status == 2'b11});
    @(posedge C); #1;
    for (int i = 0; i < 4; i++) m_buf[i] = n_buf[i];
    m_cnt = n_cnt; m_ref = n_ref; m_idx = n_idx; m_prev = bus_if.Status[1];
    m_an = n_an; m_seg = n_seg; m_err = (bus_if.Status == 2'b11);
    m_bcnt = n_bcnt; m_phase = n_phase;
    e = exp_q.pop_front();
    chk("sb_any",  {28'd0, bus_if.AnY},  {28'd0, e[14:11]});
    chk("sb_segy", {25'd0, bus_if.SegY}, {25'd0, e[10:4]});
    chk("sb_cnty", {29'd0, bus_if.CntY}, {29'd0, e[3:1]});
    chk("sb_erry", {31'd0, bus_if.ErrY}, {31'd0, e[0]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic find_digit(input logic [3:0] an, input logic [6:0] seg, input string tag);
    int n = 0;
    while (bus_if.AnY !== an && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_an"},  {28'd0, bus_if.AnY},  {28'd0, an});
    chk({tag, "_seg"}, {25'd0, bus_if.SegY}, {25'd0, seg});
  endtask

  task automatic push_sym(input logic [1:0] st, input logic [6:0] seg);
    bus_if.Status = 2'b01;
    ticks(2);
    bus_if.Status = st;
    bus_if.Seg = seg;
    ticks(3);
  endtask

  initial begin
    R = 1'b0;
    bus_if.Seg = 7'b0;
    bus_if.Status = 2'b01;
    bus_if.Clr = 1'b0;
    model_reset();
    #13;
    chk("rst_any",  {28'd0, bus_if.AnY},  32'h1);
    chk("rst_segy", {25'd0, bus_if.SegY}, 32'h0);
    chk("rst_cnty", {29'd0, bus_if.CntY}, 32'h0);
    chk("rst_erry", {31'd0, bus_if.ErrY}, 32'h0);
    @(posedge C); #1;
    R = 1'b1;

    ticks(40);
    chk("idle_cnt", {29'd0, bus_if.CntY}, 32'h0);

    bus_if.Status = 2'b10;
    bus_if.Seg = 7'b0110000;
    ticks(20);
    chk("one_push_cnt", {29'd0, bus_if.CntY}, 32'd1);
    find_digit(4'b0001, 7'b0110000, "d0_one");
    find_digit(4'b0010, 7'b0000000, "d1_blank");

    push_sym(2'b10, 7'b0110000);
    push_sym(2'b10, 7'b1101101);
    push_sym(2'b10, 7'b1111001);
    push_sym(2'b10, 7'b0110011);
    push_sym(2'b10, 7'b1011011);
    chk("full_cnt", {29'd0, bus_if.CntY}, 32'd4);
    find_digit(4'b1000, 7'b1101101, "full_d3");
    find_digit(4'b0001, 7'b1011011, "full_d0");
    find_digit(4'b0100, 7'b1111001, "full_d2");
    find_digit(4'b0010, 7'b0110011, "full_d1");

    bus_if.Status = 2'b00;
    ticks(2);
    bus_if.Status = 2'b11;
    bus_if.Seg = 7'b1001001;
    tick();
    chk("err_rise", {31'd0, bus_if.ErrY}, 32'd1);
`ifndef MORSE_DISP_BLINK_EN
    find_digit(4'b0001, 7'b1001001, "err_glyph");
`endif
    find_digit(4'b0010, 7'b1011011, "err_shift");
    bus_if.Status = 2'b00;
    tick();
    chk("err_fall", {31'd0, bus_if.ErrY}, 32'd0);

    bus_if.Status = 2'b01;
    ticks(2);
    bus_if.Status = 2'b10;
    bus_if.Seg = 7'b0110000;
    bus_if.Clr = 1'b1;
    tick();
    bus_if.Clr = 1'b0;
    ticks(10);
    chk("clr_cnt", {29'd0, bus_if.CntY}, 32'd0);
    find_digit(4'b0001, 7'b0000000, "clr_d0");

    push_sym(2'b10, 7'b1111001);
    begin
      int n = 0;
      while (bus_if.AnY !== 4'b0100 && n < 20) begin
        tick();
        n++;
      end
      chk("midscan_an", {28'd0, bus_if.AnY}, 32'h4);
    end
    #2;
    R = 1'b0;
    #1;
    chk("async_any",  {28'd0, bus_if.AnY},  32'h1);
    chk("async_segy", {25'd0, bus_if.SegY}, 32'h0);
    chk("async_cnty", {29'd0, bus_if.CntY}, 32'h0);
    model_reset();
    @(posedge C); #1;
    chk("held_cnty", {29'd0, bus_if.CntY}, 32'h0);
    R = 1'b1;
    tick();
    chk("release_push", {29'd0, bus_if.CntY}, 32'd1);

    bus_if.Status = 2'b01;
    ticks(2);
    bus_if.Status = 2'b11;
    bus_if.Seg = 7'b1001001;
    ticks(40);
    bus_if.Status = 2'b01;
    ticks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
